// File: rtl/reduce_pkg.sv
// Shared op encoding and bit-combine helpers for the reduction tree.
package reduce_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'b00;
  localparam op_t OP_OR   = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_RSVD = 2'b11;

  // Identity element used to pad an odd leftover bit; reserved behaves as AND.
  function automatic logic ident(op_t op);
    return !(op == OP_OR || op == OP_XOR);
  endfunction

  function automatic logic comb(logic a, logic b, op_t op);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Width of the vector entering tree level k for an n-bit input.
  function automatic int lvl_w(int n, int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Producer/consumer handshake bundle for reduce_tree_pipe.
interface reduce_tree_pipe_if
  import reduce_pkg::*;
#(
  parameter int N = 8
);
  logic [N-1:0] I;
  op_t          I_op;
  logic         I_valid;
  logic         I_ready;
  logic         O;
  logic         O_valid;
  logic         O_ready;

  modport master (output I, I_op, I_valid, O_ready, input I_ready, O, O_valid);
  modport slave  (input I, I_op, I_valid, O_ready, output I_ready, O, O_valid);
endinterface

// File: rtl/reduce_tree_pipe_stage.sv
// One tree level: pairwise combine of W bits into a ceil(W/2)-bit register stage.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_data,
  input  op_t                in_op,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_take,
  output logic [(W+1)/2-1:0] out_data,
  output op_t                out_op,
  output logic               out_valid
);
  localparam int WO = (W + 1) / 2;

  logic [2*WO-1:0] pad;
  logic [WO-1:0]   nxt;
  logic            load;

  if (2*WO > W) begin : g_odd
    assign pad = {ident(in_op), in_data};
  end else begin : g_even
    assign pad = in_data;
  end

  always_comb begin
    nxt = '0;
    for (int i = 0; i < WO; i++) nxt[i] = comb(pad[2*i], pad[2*i+1], in_op);
  end

  // A full stage can still accept when its contents leave this same cycle.
  assign in_ready = !out_valid || out_take;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_op    <= OP_AND;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= nxt;
      out_op    <= in_op;
      out_valid <= 1'b1;
    end else if (out_take) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N-input AND/OR/XOR reduction tree with valid/ready at both ends.
// Optional completed-handshake counter O_count under `define REDUCE_CNT_EN.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  reduce_tree_pipe_if.slave bus
`ifdef REDUCE_CNT_EN
  ,
  output logic [15:0]       O_count
`endif
);
  localparam int L = $clog2(N);

  for (genvar k = 0; k < L; k++) begin : lvl
    localparam int WI = lvl_w(N, k);
    localparam int WO = lvl_w(N, k + 1);

    logic [WI-1:0] d;
    op_t           dop;
    logic          dv;
    logic          rdy;
    logic          take;
    logic [WO-1:0] q;
    op_t           qop;
    logic          qv;

    if (k == 0) begin : g_head
      assign d   = bus.I;
      assign dop = bus.I_op;
      assign dv  = bus.I_valid;
    end else begin : g_link
      assign d   = lvl[k-1].q;
      assign dop = lvl[k-1].qop;
      assign dv  = lvl[k-1].qv;
    end

    // Drain happens when the next level (or the consumer) takes our contents.
    if (k == L - 1) begin : g_tail
      assign take = qv && bus.O_ready;
    end else begin : g_mid
      assign take = qv && lvl[k+1].rdy;
    end

    reduce_stage #(.W(WI)) u_stage (
      .clk      (CLK),
      .rst      (ASYNCRESET),
      .in_data  (d),
      .in_op    (dop),
      .in_valid (dv),
      .in_ready (rdy),
      .out_take (take),
      .out_data (q),
      .out_op   (qop),
      .out_valid(qv)
    );
  end

  assign bus.I_ready = lvl[0].rdy;
  assign bus.O       = lvl[L-1].q[0];
  assign bus.O_valid = lvl[L-1].qv;

`ifdef REDUCE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET)                                            cnt_q <= '0;
    else if (bus.O_valid && bus.O_ready && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign O_count = cnt_q;
`endif
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed bench for reduce_tree_pipe at N=8, N=5 (odd padding) and N=2.
`timescale 1ns/1ps
module tb_reduce_tree_pipe;
  import reduce_pkg::*;

  logic CLK = 1'b0;
  logic ASYNCRESET;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  reduce_tree_pipe_if #(.N(8)) b8();
  reduce_tree_pipe_if #(.N(5)) b5();
  reduce_tree_pipe_if #(.N(2)) b2();

`ifdef REDUCE_CNT_EN
  logic [15:0] cnt8, cnt5, cnt2;
  reduce_tree_pipe #(.N(8)) u8 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b8), .O_count(cnt8));
  reduce_tree_pipe #(.N(5)) u5 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b5), .O_count(cnt5));
  reduce_tree_pipe #(.N(2)) u2 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b2), .O_count(cnt2));
`else
  reduce_tree_pipe #(.N(8)) u8 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b8));
  reduce_tree_pipe #(.N(5)) u5 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b5));
  reduce_tree_pipe #(.N(2)) u2 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b2));
`endif

  // Output monitors: every completed output handshake, with its cycle stamp.
  logic q8[$];
  int   t8[$];
  logic q2[$];
  always @(negedge CLK) begin
    if (b8.O_valid && b8.O_ready) begin q8.push_back(b8.O); t8.push_back(cyc); end
    if (b2.O_valid && b2.O_ready) q2.push_back(b2.O);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ov(input int n);
    case (n)
      8:       return b8.O_valid;
      5:       return b5.O_valid;
      default: return b2.O_valid;
    endcase
  endfunction

  function automatic logic oo(input int n);
    case (n)
      8:       return b8.O;
      5:       return b5.O;
      default: return b2.O;
    endcase
  endfunction

  task automatic drive(input int n, input logic [7:0] v, input op_t op);
    case (n)
      8:       begin b8.I = v;      b8.I_op = op; b8.I_valid = 1'b1; end
      5:       begin b5.I = v[4:0]; b5.I_op = op; b5.I_valid = 1'b1; end
      default: begin b2.I = v[1:0]; b2.I_op = op; b2.I_valid = 1'b1; end
    endcase
  endtask

  task automatic idle();
    b8.I_valid = 1'b0; b5.I_valid = 1'b0; b2.I_valid = 1'b0;
  endtask

  // Single vector into an idle, unstalled pipe: check latency and result.
  task automatic lat(input int n, input logic [7:0] v, input op_t op,
                     input logic exp, input int elat, input string tag);
    int c;
    drive(n, v, op);
    @(posedge CLK); #1;
    idle();
    c = 1;
    while (!ov(n) && c < 20) begin @(posedge CLK); #1; c++; end
    chk({tag, "_lat"}, c, elat);
    chk({tag, "_o"}, oo(n), exp);
    @(posedge CLK); #1;
  endtask

  logic [7:0] bp_v  [5] = '{8'hFF, 8'h00, 8'h01, 8'hAA, 8'h55};
  op_t        bp_op [5] = '{OP_AND, OP_OR, OP_XOR, OP_AND, OP_AND};
  logic [7:0] bb_v  [4] = '{8'hFF, 8'h00, 8'h03, 8'h7F};
  op_t        bb_op [4] = '{OP_AND, OP_OR, OP_XOR, OP_AND};
  logic [1:0] n2_v  [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
  op_t        n2_op [4] = '{OP_OR, OP_XOR, OP_XOR, OP_AND};
  logic       n2_e  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int  acc;
    logic r;
    ASYNCRESET = 1'b1;
    b8.I = '0; b8.I_op = OP_AND; b8.I_valid = 1'b0; b8.O_ready = 1'b1;
    b5.I = '0; b5.I_op = OP_AND; b5.I_valid = 1'b0; b5.O_ready = 1'b1;
    b2.I = '0; b2.I_op = OP_AND; b2.I_valid = 1'b0; b2.O_ready = 1'b1;
    #1;
    chk("rst_ov", b8.O_valid, 1'b0);
    chk("rst_o", b8.O, 1'b0);
    chk("rst_irdy", b8.I_ready, 1'b1);
    repeat (2) @(posedge CLK);
    #1 ASYNCRESET = 1'b0;

    // Basic N=8 latency and AND results
    lat(8, 8'hFF, OP_AND, 1'b1, 3, "n8_ff_and");
    lat(8, 8'hFE, OP_AND, 1'b0, 3, "n8_fe_and");

    // N=5 odd-width padding
    lat(5, 8'h10, OP_OR,   1'b1, 3, "n5_or");
    lat(5, 8'h10, OP_XOR,  1'b1, 3, "n5_xor1");
    lat(5, 8'h1F, OP_XOR,  1'b1, 3, "n5_xor5");
    lat(5, 8'h1F, OP_AND,  1'b1, 3, "n5_and");
    lat(5, 8'h1E, OP_RSVD, 1'b0, 3, "n5_rsvd");

    // Back-to-back mixed ops
    q8.delete(); t8.delete();
    for (int j = 0; j < 4; j++) begin
      drive(8, bb_v[j], bb_op[j]);
      @(posedge CLK); #1;
    end
    idle();
    repeat (5) @(posedge CLK);
    #1;
    chk("bb_cnt", q8.size(), 4);
    if (q8.size() == 4) begin
      chk("bb_o0", q8[0], 1'b1);
      chk("bb_o1", q8[1], 1'b0);
      chk("bb_o2", q8[2], 1'b0);
      chk("bb_o3", q8[3], 1'b0);
      chk("bb_gap", t8[3] - t8[0], 3);
    end

    // Backpressure: fill with O_ready low, then release
    q8.delete();
    b8.O_ready = 1'b0;
    acc = 0;
    drive(8, bp_v[0], bp_op[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      r = b8.I_ready;
      if (b8.O_valid) chk("bp_o_hold", b8.O, 1'b1);
      @(posedge CLK); #1;
      if (r) acc++;
      drive(8, bp_v[acc], bp_op[acc]);
    end
    chk("bp_accepted", acc, 3);
    chk("bp_irdy_low", b8.I_ready, 1'b0);
    idle();
    b8.O_ready = 1'b1;
    #1;
    chk("bp_irdy_rise", b8.I_ready, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    chk("bp_cnt", q8.size(), 3);
    if (q8.size() == 3) begin
      chk("bp_o0", q8[0], 1'b1);
      chk("bp_o1", q8[1], 1'b0);
      chk("bp_o2", q8[2], 1'b1);
    end

    // Reset with two results in flight
    b8.O_ready = 1'b0;
    drive(8, 8'hFF, OP_AND); @(posedge CLK); #1;
    drive(8, 8'h00, OP_OR);  @(posedge CLK); #1;
    idle();
    @(posedge CLK); #1;
    chk("mrst_pre_ov", b8.O_valid, 1'b1);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("mrst_ov", b8.O_valid, 1'b0);
    chk("mrst_o", b8.O, 1'b0);
    chk("mrst_irdy", b8.I_ready, 1'b1);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b0;
    q8.delete();
    b8.O_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("mrst_stale", q8.size(), 0);
`ifdef REDUCE_CNT_EN
    chk("cnt_rst", cnt2, 16'd0);
`endif

    // N=2: one-cycle latency then a back-to-back burst
    lat(2, 8'h03, OP_AND, 1'b1, 1, "n2_and");
    q2.delete();
    for (int j = 0; j < 4; j++) begin
      drive(2, {6'd0, n2_v[j]}, n2_op[j]);
      @(posedge CLK); #1;
    end
    idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("n2_cnt", q2.size(), 4);
    if (q2.size() == 4)
      for (int j = 0; j < 4; j++) chk($sformatf("n2_o%0d", j), q2[j], n2_e[j]);

`ifdef REDUCE_CNT_EN
    chk("cnt_5", cnt2, 16'd5);
    force u2.cnt_q = 16'hFFFE;
    @(posedge CLK); #1;
    release u2.cnt_q;
    chk("cnt_preload", cnt2, 16'hFFFE);
    for (int j = 0; j < 3; j++) begin
      drive(2, 8'h03, OP_AND);
      @(posedge CLK); #1;
    end
    idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("cnt_sat", cnt2, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/reduce_tree_pipe.md
# reduce_tree_pipe

Parametrised, pipelined bit-reduction engine that generalises the fixed two-input AND gate to N inputs and three runtime-selectable operations (AND, OR, XOR). It uses a valid/ready handshake at both ends. Each tree level is a register stage, and stages collapse bubbles independently. It sits between a producer of N-bit flag vectors (status collectors, parity sources) and a single-bit consumer.

## Interface
Parameters:
- N, 8: input vector width; legal range 2..64.
- L, derived, clog2(N): number of tree levels and register stages; not overridable.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I  input  N  operand vector; sampled on input handshake.
- I_op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 reserved (executes as AND); sampled with I.
- I_valid  input  1  producer has a vector.
- I_ready  output  1  block accepts a vector this cycle.
- O  output  1  reduction result.
- O_valid  output  1  O holds a result.
- O_ready  input  1  consumer accepts O this cycle.
- O_count  output  16  completed output handshakes (present only with REDUCE_CNT_EN).

## Operation
- Level k (k=0..L-1) holds a partial vector of width ceil(N/2^(k+1)), a latched op, and a valid bit.
- The last level's partial vector is 1 bit wide and drives O; its valid bit drives O_valid.
- Each level combines adjacent pairs of its input with the latched op. An odd leftover bit is paired with the identity element: 1 for AND, 0 for OR/XOR.
- The op travels with its data, so results with different ops may be in flight at once.
- Load rule: level k loads when its upstream valid is set and (level k empty OR level k drains this cycle).
  - Level L-1 drains when O_valid and O_ready are both high.
  - Level k<L-1 drains when level k+1 loads.
  - If level k drains without loading, its valid bit clears.
- I_ready = level 0 load condition with the upstream valid term excluded, i.e. (level 0 empty OR level 0 drains). Combinational path O_ready→I_ready is permitted.
- An input handshake occurs when I_valid && I_ready.
- Results are delivered strictly in acceptance order; no reordering or dropping.
- Reset (asserted at any time, including mid-stream):
  - all valid bits 0, partial vectors 0, ops 00;
  - O=0, O_valid=0, I_ready=1;
  - in-flight results are discarded;
  - O_count=0.
- O and the data registers hold their value while O_valid && !O_ready. Data may change only after a drain.

## Timing
- Latency: L cycles from input handshake to O_valid, with an unstalled output. N=2: 1 cycle. N=8: 3 cycles. N=64: 6 cycles.
- Throughput: one vector per cycle with O_ready held high.
- Backpressure:
  - With O_ready low, the pipeline fills; I_ready falls after exactly L accepted vectors that have not drained.
  - When O_ready rises, I_ready rises in that same cycle.
- Bubbles: an empty level k accepts even while level k+1 is stalled.
- Simultaneous drain and load at the last level: the new result appears on the next cycle with O_valid continuously high.

## Configuration
- REDUCE_CNT_EN defined:
  - O_count exists;
  - it increments on each O_valid && O_ready cycle;
  - it saturates at 16'hFFFF;
  - it resets to 0 on ASYNCRESET.
- Undefined: the O_count port and counter are absent. Datapath and handshake behaviour are identical either way.

## Structure
- Package reduce_pkg holds:
  - the op_t 2-bit typedef, with constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_RSVD=2'b11;
  - the identity-element function ident(op);
  - the pairwise combine function comb(a,b,op).
- Sub-module reduce_stage is parametrised by input width W. It contains:
  - the combine logic;
  - the output register (ceil(W/2) bits);
  - the op and valid registers;
  - the local load/drain logic.
- The top instantiates L reduce_stage instances in a generate loop. It adds the optional counter.

## Test plan
- N=8, O_ready=1, one vector I=8'hFF, op=AND → O_valid exactly 3 cycles later with O=1. Then I=8'hFE, op=AND → O=0.
- N=5 (odd padding): I=5'b10000 with OR → O=1, and with XOR → O=1. I=5'b11111 with XOR → O=1. I=5'b11111 with AND → O=1. Op 11 with I=5'b11110 → O=0.
- N=8 back-to-back: 4 consecutive vectors with ops AND, OR, XOR, AND (I=FF, 00, 03, 7F) → O sequence 1,0,0,0 on consecutive cycles.
- Backpressure, N=8: hold O_ready=0 and drive I_valid continuously → exactly 3 accepted, then I_ready=0. O stays stable throughout. Raise O_ready → I_ready=1 the same cycle, and all results emerge in order.
- Reset mid-stream: assert ASYNCRESET between clock edges with 2 results in flight → O_valid=0 immediately. After release, no stale result emerges.
- REDUCE_CNT_EN, N=2: 5 output handshakes → O_count=5. Preload 16'hFFFE via force, then 3 handshakes → O_count=16'hFFFF.
